// File: rtl/seg_display_arbiter.sv
// Fixed-priority owner of the 8-digit seven-segment display with a minimum-hold guarantee; scans the owner's digits.
// Optional blink masks are compiled in with `define SEG_BLINK_EN.
module seg_display_arbiter #(
   parameter int DIV          = 100000,
   parameter int MIN_FRAMES   = 4,
   parameter int BLINK_FRAMES = 64
) (
   input  logic        CLK100MHZ,
   input  logic        BTNU,
   input  logic [2:0]  req,
   input  logic [31:0] data0,
   input  logic [31:0] data1,
   input  logic [31:0] data2,
   input  logic [7:0]  blank0,
   input  logic [7:0]  blank1,
   input  logic [7:0]  blank2,
`ifdef SEG_BLINK_EN
   input  logic [7:0]  blink0,
   input  logic [7:0]  blink1,
   input  logic [7:0]  blink2,
`endif
   output logic [2:0]  gnt,
   output logic        frame_tick,
   output logic [7:0]  AN,
   output logic [7:0]  seg
);
   localparam int DW = (DIV > 1) ? $clog2(DIV) : 1;
   localparam int HW = $clog2(MIN_FRAMES + 1);

   typedef enum logic {S_IDLE, S_OWN} state_t;

   state_t          state_q, state_n;
   logic [DW-1:0]   div_q, div_n;
   logic [2:0]      idx_q, idx_n;
   logic [1:0]      owner_q, owner_n, hi;
   logic [HW-1:0]   hold_q, hold_n;
   logic            slot_tick, bound, hi_valid, blink_off;
   logic [31:0]     data_sel;
   logic [7:0]      blank_sel, an_n, seg_n;
   logic [3:0]      nib;
   logic [2:0]      gnt_n;

   function automatic logic [6:0] glyph(input logic [3:0] n);
      case (n)
         4'h0: glyph = 7'h40;  4'h1: glyph = 7'h79;  4'h2: glyph = 7'h24;  4'h3: glyph = 7'h30;
         4'h4: glyph = 7'h19;  4'h5: glyph = 7'h12;  4'h6: glyph = 7'h02;  4'h7: glyph = 7'h78;
         4'h8: glyph = 7'h00;  4'h9: glyph = 7'h10;  4'hA: glyph = 7'h08;  4'hB: glyph = 7'h03;
         4'hC: glyph = 7'h46;  4'hD: glyph = 7'h21;  4'hE: glyph = 7'h06;  default: glyph = 7'h0E;
      endcase
   endfunction

   always_comb begin
      slot_tick = (div_q == DW'(DIV - 1));
      bound     = slot_tick && (idx_q == 3'd7);
      div_n     = slot_tick ? '0 : div_q + 1'b1;
      idx_n     = slot_tick ? idx_q + 3'd1 : idx_q;
      hi_valid  = |req;
      hi        = req[0] ? 2'd0 : (req[1] ? 2'd1 : 2'd2);
      state_n   = state_q;
      owner_n   = owner_q;
      hold_n    = hold_q;
      if (bound) begin
         case (state_q)
            S_IDLE: begin
               if (hi_valid) begin
                  state_n = S_OWN;
                  owner_n = hi;
                  hold_n  = '0;
               end
            end
            default: begin
               // Release ignores the hold counter; preemption needs a full hold.
               if (!req[owner_q]) begin
                  hold_n = '0;
                  if (hi_valid) owner_n = hi;
                  else          state_n = S_IDLE;
               end else if (hi < owner_q && hold_q >= HW'(MIN_FRAMES)) begin
                  owner_n = hi;
                  hold_n  = '0;
               end else if (hold_q < HW'(MIN_FRAMES)) begin
                  hold_n = hold_q + 1'b1;
               end
            end
         endcase
      end
   end

`ifdef SEG_BLINK_EN
   localparam int BW = (BLINK_FRAMES > 1) ? $clog2(BLINK_FRAMES) : 1;
   logic [BW-1:0] fcnt_q, fcnt_n;
   logic          phase_q, phase_n;
   logic [7:0]    blink_sel;

   always_comb begin
      fcnt_n  = fcnt_q;
      phase_n = phase_q;
      if (bound) begin
         if (fcnt_q == BW'(BLINK_FRAMES - 1)) begin
            fcnt_n  = '0;
            phase_n = ~phase_q;
         end else begin
            fcnt_n = fcnt_q + 1'b1;
         end
      end
      case (owner_n)
         2'd1:    blink_sel = blink1;
         2'd2:    blink_sel = blink2;
         default: blink_sel = blink0;
      endcase
      blink_off = phase_n && blink_sel[idx_n];
   end

   always_ff @(posedge CLK100MHZ) begin
      if (BTNU) begin
         fcnt_q  <= '0;
         phase_q <= 1'b0;
      end else begin
         fcnt_q  <= fcnt_n;
         phase_q <= phase_n;
      end
   end
`else
   always_comb blink_off = 1'b0;
`endif

   // Outputs are built from next-cycle scan position and owner so a new grant lands on digit 0.
   always_comb begin
      case (owner_n)
         2'd1:    begin data_sel = data1; blank_sel = blank1; end
         2'd2:    begin data_sel = data2; blank_sel = blank2; end
         default: begin data_sel = data0; blank_sel = blank0; end
      endcase
      nib   = data_sel[{idx_n, 2'b00} +: 4];
      an_n  = 8'hFF;
      seg_n = 8'hFF;
      gnt_n = 3'b000;
      if (state_n == S_OWN) begin
         gnt_n = 3'b001 << owner_n;
         seg_n = {1'b1, glyph(nib)};
         if (!(blank_sel[idx_n] || blink_off)) an_n = ~(8'd1 << idx_n);
      end
   end

   always_ff @(posedge CLK100MHZ) begin
      if (BTNU) begin
         div_q      <= '0;
         idx_q      <= '0;
         state_q    <= S_IDLE;
         owner_q    <= '0;
         hold_q     <= '0;
         gnt        <= '0;
         frame_tick <= 1'b0;
         AN         <= 8'hFF;
         seg        <= 8'hFF;
      end else begin
         div_q      <= div_n;
         idx_q      <= idx_n;
         state_q    <= state_n;
         owner_q    <= owner_n;
         hold_q     <= hold_n;
         gnt        <= gnt_n;
         frame_tick <= bound;
         AN         <= an_n;
         seg        <= seg_n;
      end
   end
endmodule

// File: tb/tb_seg_display_arbiter.sv
// Bench for seg_display_arbiter: frame-position model checked every cycle plus directed literal checks.
module tb_seg_display_arbiter;
   localparam int DIV = 4, MINF = 2, BLINKF = 2, FRAME = 8 * DIV;

   logic clk = 1'b0, rst = 1'b1;
   logic [2:0] req = '0;
   logic [31:0] data0 = '0, data1 = '0, data2 = '0;
   logic [7:0] blank0 = '0, blank1 = '0, blank2 = '0;
`ifdef SEG_BLINK_EN
   logic [7:0] blink0 = '0, blink1 = '0, blink2 = '0;
`endif
   logic [2:0] gnt;
   logic frame_tick;
   logic [7:0] AN, seg;

   int tests = 0, fails = 0;
   bit chk_en = 0;

   seg_display_arbiter #(.DIV(DIV), .MIN_FRAMES(MINF), .BLINK_FRAMES(BLINKF)) dut (
      .CLK100MHZ(clk), .BTNU(rst), .req(req),
      .data0(data0), .data1(data1), .data2(data2),
      .blank0(blank0), .blank1(blank1), .blank2(blank2),
`ifdef SEG_BLINK_EN
      .blink0(blink0), .blink1(blink1), .blink2(blink2),
`endif
      .gnt(gnt), .frame_tick(frame_tick), .AN(AN), .seg(seg));

   always #5 clk = ~clk;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      tests++;
      if (act !== exp) begin
         fails++;
         $display("FAIL %s at %0t: got %h expected %h", name, $time, act, exp);
      end
   endtask

   function automatic logic [6:0] gl(input logic [3:0] n);
      logic [6:0] t [16];
      t = '{7'h40, 7'h79, 7'h24, 7'h30, 7'h19, 7'h12, 7'h02, 7'h78,
            7'h00, 7'h10, 7'h08, 7'h03, 7'h46, 7'h21, 7'h06, 7'h0E};
      return t[n];
   endfunction

   function automatic int lowest(input logic [2:0] r);
      for (int i = 0; i < 3; i++) if (r[i]) return i;
      return -1;
   endfunction

   // Model: position within the frame, owner index (-1 = none), frames held.
   int pos = 0, own = -1, hold = 0, frames = 0;
   logic m_ft = 0;
   logic [2:0] m_gnt = 0;
   logic [7:0] m_an = 8'hFF, m_seg = 8'hFF;

   always @(posedge clk) begin
      int p, dig;
      logic [31:0] d;
      logic [7:0] bl, bk;
      if (rst) begin
         pos = 0; own = -1; hold = 0; frames = 0; m_ft = 0;
      end else begin
         m_ft = (pos == FRAME - 1);
         if (m_ft) begin
            frames++;
            p = lowest(req);
            if (own < 0) begin
               own = p; hold = 0;
            end else if (!req[own]) begin
               own = p; hold = 0;
            end else if (p < own && hold >= MINF) begin
               own = p; hold = 0;
            end else if (hold < MINF) hold++;
         end
         pos = (pos + 1) % FRAME;
      end
      dig = pos / DIV;
      m_an = 8'hFF; m_seg = 8'hFF; m_gnt = 0;
      if (own >= 0) begin
         d  = (own == 0) ? data0 : (own == 1) ? data1 : data2;
         bl = (own == 0) ? blank0 : (own == 1) ? blank1 : blank2;
         bk = 8'h00;
`ifdef SEG_BLINK_EN
         if ((frames / BLINKF) % 2 == 1) bk = (own == 0) ? blink0 : (own == 1) ? blink1 : blink2;
`endif
         m_gnt = 3'(1 << own);
         m_seg = {1'b1, gl(d[dig*4 +: 4])};
         if (!bl[dig] && !bk[dig]) m_an = ~(8'(1) << dig);
      end
   end

   always @(negedge clk) begin
      if (chk_en) begin
         chk("model_an", {24'd0, AN}, {24'd0, m_an});
         if (m_an != 8'hFF || m_gnt == 0) chk("model_seg", {24'd0, seg}, {24'd0, m_seg});
         chk("model_gnt", {29'd0, gnt}, {29'd0, m_gnt});
         chk("model_frame_tick", {31'd0, frame_tick}, {31'd0, m_ft});
      end
   end

   task automatic adv(input int n);
      repeat (n) @(negedge clk);
   endtask

   task automatic wait_ftick();
      int n = 0;
      do begin
         @(negedge clk);
         n++;
      end while (!frame_tick && n < 4 * FRAME);
      if (!frame_tick) chk("frame_tick_timeout", 32'd0, 32'd1);
   endtask

   initial begin
      logic [7:0] exp_an [8];
      logic [7:0] exp_seg [4];
      int nt, nb;
      exp_an  = '{8'hFE, 8'hFD, 8'hFB, 8'hF7, 8'hFF, 8'hFF, 8'hFF, 8'hFF};
      exp_seg = '{8'h99, 8'hB0, 8'hA4, 8'hF9};

      adv(3);
      chk("reset_an", {24'd0, AN}, 32'hFF);
      chk("reset_seg", {24'd0, seg}, 32'hFF);
      chk("reset_gnt", {29'd0, gnt}, 32'd0);
      chk("reset_frame_tick", {31'd0, frame_tick}, 32'd0);
      rst = 0;
      chk_en = 1;

      nt = 0;
      for (int i = 0; i < 64; i++) begin
         adv(1);
         if (frame_tick) nt++;
      end
      chk("idle_frame_ticks", nt, 32'd2);

      req = 3'b100; data2 = 32'h0000_1234; blank2 = 8'hF0;
      data0 = 32'h89AB_CDEF; data1 = 32'h0000_00C5;
      wait_ftick();
      chk("grant2", {29'd0, gnt}, 32'b100);
      for (int d = 0; d < 8; d++) begin
         if (d > 0) adv(DIV);
         chk("req2_an", {24'd0, AN}, {24'd0, exp_an[d]});
         if (d < 4) chk("req2_seg", {24'd0, seg}, {24'd0, exp_seg[d]});
      end

      req = 3'b101;
      wait_ftick(); chk("hold_1", {29'd0, gnt}, 32'b100);
      wait_ftick(); chk("hold_2", {29'd0, gnt}, 32'b100);
      wait_ftick(); chk("preempt_0", {29'd0, gnt}, 32'b001);
      chk("preempt_seg", {24'd0, seg}, 32'h8E);

      req = 3'b011;
      for (int i = 0; i < 3; i++) begin
         wait_ftick(); chk("no_low_preempt", {29'd0, gnt}, 32'b001);
      end
      req = 3'b010;
      wait_ftick();
      chk("release_to_1", {29'd0, gnt}, 32'b010);
      chk("release_seg", {24'd0, seg}, 32'h92);

      adv(10); req = 3'b011; adv(5); req = 3'b010;
      wait_ftick();
      chk("pulse_ignored", {29'd0, gnt}, 32'b010);

      adv(10); rst = 1; adv(1);
      chk("midreset_gnt", {29'd0, gnt}, 32'd0);
      chk("midreset_an", {24'd0, AN}, 32'hFF);
      rst = 0;
      nt = 0;
      do begin
         adv(1);
         nt++;
      end while (!frame_tick && nt < 4 * FRAME);
      chk("restart_cycles", nt, 32'd32);
      chk("restart_gnt", {29'd0, gnt}, 32'b010);
      chk("restart_an", {24'd0, AN}, 32'hFE);

`ifdef SEG_BLINK_EN
      blink0 = 8'h01;
`endif
      req = 3'b001;
      wait_ftick();
      chk("blink_owner", {29'd0, gnt}, 32'b001);
      nb = 0;
      for (int f = 0; f < 4; f++) begin
         wait_ftick();
         if (AN == 8'hFF) nb++;
         adv(DIV);
         chk("blink_digit1", {24'd0, AN}, 32'hFD);
      end
`ifdef SEG_BLINK_EN
      chk("blink_off_frames", nb, 32'd2);
`else
      chk("blink_off_frames", nb, 32'd0);
`endif

      adv(2);
      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not finish");
      $fatal(1);
   end
endmodule
